// File: rtl/simon_key_expand_pkg.sv
// Shared Simon128/256 key-schedule types, constants and the per-step
// round-key recurrence used by the expander.
package simon_pkg;

  localparam int SIMON_N = 64;
  localparam int SIMON_M = 4;
  localparam int SIMON_T = 72;
  localparam logic [61:0] SIMON_Z4 = 62'h3DC94C3A046D678B;

  typedef logic [63:0] simon_word_t;

  typedef enum logic [1:0] {
    KS_IDLE,
    KS_HOLD,
    KS_STREAM
  } ks_state_e;

  // Next key word from window words 0, 1 and 3 and the current z bit.
  function automatic simon_word_t simon_ks_next(input simon_word_t w0,
                                                input simon_word_t w1,
                                                input simon_word_t w3,
                                                input logic        zbit);
    simon_word_t t;
    t = {w3[2:0], w3[63:3]} ^ w1;
    t = t ^ {t[0], t[63:1]};
    return ~w0 ^ t ^ {63'd0, zbit} ^ 64'h3;
  endfunction

endpackage

// File: rtl/simon_key_expand_if.sv
// Master-key load and round-key stream bundle between the config block,
// the key expander (master side) and the round core.
interface simon_key_expand_if;
  logic [255:0] key_data;
  logic         key_valid;
  logic         key_ready;
  logic         replay;
  logic [63:0]  rk_data;
  logic [6:0]   rk_idx;
  logic         rk_valid;
  logic         rk_ready;
  logic         rk_last;
  logic         key_loaded;

  modport master (
    input  key_data, key_valid, replay, rk_ready,
    output key_ready, rk_data, rk_idx, rk_valid, rk_last, key_loaded
  );

  modport slave (
    output key_data, key_valid, replay, rk_ready,
    input  key_ready, rk_data, rk_idx, rk_valid, rk_last, key_loaded
  );
endinterface

// File: rtl/simon_key_expand.sv
// Streaming Simon128/256 key schedule: holds the master key plus a 4-word
// sliding window and emits one round key per accepted beat.
module simon_key_expand
  import simon_pkg::*;
#(
  parameter int          WORD_WIDTH = 64,
  parameter int          KEY_WORDS  = 4,
  parameter int          ROUNDS     = 72,
  parameter logic [61:0] Z_SEQ      = 62'h3DC94C3A046D678B
) (
  input  logic                 clk_simon_data,
  input  logic                 rst_simon_data,
  simon_key_expand_if.master   ks
);

  if (WORD_WIDTH != SIMON_N || KEY_WORDS != SIMON_M) begin : g_bad_cfg
    $error("simon_key_expand supports only WORD_WIDTH=64, KEY_WORDS=4");
  end

  ks_state_e    state_q, state_d;
  simon_word_t  w_q [4];
  logic [255:0] mkey_q;
  logic [6:0]   idx_q;
  logic [5:0]   zcnt_q;
  logic         loaded_q;

  logic         key_acc;
  logic         replay_acc;
  logic         beat;
  logic         last_beat;
  simon_word_t  knew;

  assign ks.key_ready = !rst_simon_data && (state_q != KS_STREAM);
  assign key_acc      = ks.key_valid && ks.key_ready;
  // A new key in the same cycle as replay takes priority.
  assign replay_acc   = ks.replay && (state_q == KS_HOLD) && !key_acc;
  assign beat         = (state_q == KS_STREAM) && ks.rk_ready;
  assign last_beat    = beat && (idx_q == 7'(ROUNDS - 1));
  assign knew         = simon_ks_next(w_q[0], w_q[1], w_q[3], Z_SEQ[zcnt_q]);

  assign ks.rk_data    = w_q[0];
  assign ks.rk_idx     = idx_q;
  assign ks.rk_valid   = (state_q == KS_STREAM);
  assign ks.rk_last    = (state_q == KS_STREAM) && (idx_q == 7'(ROUNDS - 1));
  assign ks.key_loaded = loaded_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      KS_IDLE:   if (key_acc)                state_d = KS_STREAM;
      KS_HOLD:   if (key_acc || replay_acc)  state_d = KS_STREAM;
      KS_STREAM: if (last_beat)              state_d = KS_HOLD;
      default:                               state_d = KS_IDLE;
    endcase
  end

  always_ff @(posedge clk_simon_data) begin
    if (rst_simon_data) state_q <= KS_IDLE;
    else                state_q <= state_d;
  end

  always_ff @(posedge clk_simon_data) begin
    if (rst_simon_data) begin
      for (int i = 0; i < 4; i++) w_q[i] <= '0;
      mkey_q   <= '0;
      idx_q    <= '0;
      zcnt_q   <= '0;
      loaded_q <= 1'b0;
    end else if (key_acc) begin
      for (int i = 0; i < 4; i++) w_q[i] <= ks.key_data[64*i +: 64];
      mkey_q   <= ks.key_data;
      idx_q    <= '0;
      zcnt_q   <= '0;
      loaded_q <= 1'b1;
    end else if (replay_acc) begin
      for (int i = 0; i < 4; i++) w_q[i] <= mkey_q[64*i +: 64];
      idx_q  <= '0;
      zcnt_q <= '0;
    end else if (last_beat) begin
      idx_q  <= '0;
      zcnt_q <= '0;
    end else if (beat) begin
      w_q[0] <= w_q[1];
      w_q[1] <= w_q[2];
      w_q[2] <= w_q[3];
      w_q[3] <= knew;
      idx_q  <= idx_q + 7'd1;
      zcnt_q <= (zcnt_q == 6'd61) ? 6'd0 : zcnt_q + 6'd1;
    end
  end

endmodule

// File: tb/tb_simon_key_expand.sv
// Directed bench for simon_key_expand: schedule contents, Simon128/256 known
// answer through a behavioural round core, backpressure, replay and reset.
module tb_simon_key_expand;
  import simon_pkg::*;

  localparam logic [255:0] K1 =
    256'h1f1e1d1c1b1a1918_1716151413121110_0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [255:0] K2 =
    256'h0123456789abcdef_fedcba9876543210_a5a5a5a55a5a5a5a_1122334455667788;
  localparam logic [127:0] PT = 128'h74206e69206d6f6f6d69732061207369;
  localparam logic [127:0] CT = 128'h8d2b5579afc8a3a03bf72a87efe7b868;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  simon_key_expand_if bus ();

  simon_key_expand #(
    .WORD_WIDTH(64),
    .KEY_WORDS (4),
    .ROUNDS    (72),
    .Z_SEQ     (62'h3DC94C3A046D678B)
  ) dut (
    .clk_simon_data(clk),
    .rst_simon_data(rst),
    .ks            (bus)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;
  simon_word_t mdl [72];
  simon_word_t got [72];

  task automatic set_model(input logic [255:0] k);
    logic [61:0] z;
    z = SIMON_Z4;
    for (int i = 0; i < 4; i++) mdl[i] = k[64*i +: 64];
    for (int i = 0; i < 68; i++)
      mdl[i+4] = simon_ks_next(mdl[i], mdl[i+1], mdl[i+3], z[i % 62]);
  endtask

  function automatic simon_word_t rol(input simon_word_t x, input int s);
    return (x << s) | (x >> (64 - s));
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    simon_word_t x, y, t;
    x = pt[127:64];
    y = pt[63:0];
    for (int i = 0; i < 72; i++) begin
      t = x;
      x = y ^ ((rol(x, 1) & rol(x, 8)) ^ rol(x, 2)) ^ got[i];
      y = t;
    end
    return {x, y};
  endfunction

  function automatic int model_errs();
    int e = 0;
    for (int i = 0; i < 72; i++) if (got[i] !== mdl[i]) e++;
    return e;
  endfunction

  task automatic load_key(input logic [255:0] k, input logic with_replay);
    bus.key_data  = k;
    bus.key_valid = 1'b1;
    bus.replay    = with_replay;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.replay    = 1'b0;
  endtask

  task automatic pulse_replay();
    bus.replay = 1'b1;
    @(negedge clk);
    bus.replay = 1'b0;
  endtask

  // Consume one schedule; observation is at negedge, away from the active edge.
  task automatic collect(input int pct, output int nbeats, output int bad_idx,
                         output int bad_last, output int bad_stable, output int span);
    int cyc = 0;
    int first = -1;
    bit stalled = 0;
    simon_word_t pd = '0;
    logic [6:0] pi = '0;
    logic pl = 1'b0;
    nbeats = 0; bad_idx = 0; bad_last = 0; bad_stable = 0; span = 0;
    while (nbeats < 72 && cyc < 1000) begin
      bus.rk_ready = (pct >= 100) ? 1'b1 : ($urandom_range(99) < 32'(pct));
      if (stalled && (bus.rk_data !== pd || bus.rk_idx !== pi || bus.rk_last !== pl))
        bad_stable++;
      stalled = 0;
      if (bus.rk_valid === 1'b1) begin
        if (bus.rk_ready) begin
          if (bus.rk_idx !== 7'(nbeats)) bad_idx++;
          if (bus.rk_last !== (nbeats == 71)) bad_last++;
          got[nbeats] = bus.rk_data;
          if (first < 0) first = cyc;
          if (nbeats == 71) span = cyc - first + 1;
          nbeats++;
        end else begin
          stalled = 1;
          pd = bus.rk_data;
          pi = bus.rk_idx;
          pl = bus.rk_last;
        end
      end
      cyc++;
      @(negedge clk);
    end
    bus.rk_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.key_data = '0; bus.key_valid = 1'b0; bus.replay = 1'b0; bus.rk_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk_cnt++; if (bus.key_ready !== 1'b1) $display("FAIL reset_key_ready: got %b want 1", bus.key_ready); else pass_cnt++;
    chk_cnt++; if (bus.rk_valid !== 1'b0) $display("FAIL reset_rk_valid: got %b want 0", bus.rk_valid); else pass_cnt++;
    chk_cnt++; if (bus.key_loaded !== 1'b0) $display("FAIL reset_key_loaded: got %b want 0", bus.key_loaded); else pass_cnt++;
    chk_cnt++; if (bus.rk_idx !== 7'd0) $display("FAIL reset_rk_idx: got %0d want 0", bus.rk_idx); else pass_cnt++;
    chk_cnt++; if (bus.rk_data !== 64'd0) $display("FAIL reset_rk_data: got %h want 0", bus.rk_data); else pass_cnt++;
  endtask

  task automatic test_stream();
    int n, bi, bl, bs, sp, e;
    logic [127:0] ct;
    set_model(K1);
    load_key(K1, 1'b0);
    collect(100, n, bi, bl, bs, sp);
    e  = model_errs();
    ct = encrypt(PT);
    chk_cnt++; if (n != 72) $display("FAIL stream_beats: got %0d want 72", n); else pass_cnt++;
    chk_cnt++; if (bi != 0) $display("FAIL stream_idx_order: got %0d bad want 0", bi); else pass_cnt++;
    chk_cnt++; if (bl != 0) $display("FAIL stream_last: got %0d bad want 0", bl); else pass_cnt++;
    chk_cnt++; if (sp != 72) $display("FAIL stream_span: got %0d cycles want 72", sp); else pass_cnt++;
    chk_cnt++; if (got[0] !== 64'h0706050403020100) $display("FAIL stream_rk0: got %h want 0706050403020100", got[0]); else pass_cnt++;
    chk_cnt++; if (got[1] !== 64'h0f0e0d0c0b0a0908) $display("FAIL stream_rk1: got %h want 0f0e0d0c0b0a0908", got[1]); else pass_cnt++;
    chk_cnt++; if (got[2] !== 64'h1716151413121110) $display("FAIL stream_rk2: got %h want 1716151413121110", got[2]); else pass_cnt++;
    chk_cnt++; if (got[3] !== 64'h1f1e1d1c1b1a1918) $display("FAIL stream_rk3: got %h want 1f1e1d1c1b1a1918", got[3]); else pass_cnt++;
    chk_cnt++; if (e != 0) $display("FAIL stream_model: got %0d wrong keys want 0", e); else pass_cnt++;
    chk_cnt++; if (ct !== CT) $display("FAIL stream_cipher: got %h want %h", ct, CT); else pass_cnt++;
    chk_cnt++; if (bus.rk_valid !== 1'b0) $display("FAIL stream_done_valid: got %b want 0", bus.rk_valid); else pass_cnt++;
    chk_cnt++; if (bus.key_loaded !== 1'b1) $display("FAIL stream_key_loaded: got %b want 1", bus.key_loaded); else pass_cnt++;
    chk_cnt++; if (bus.key_ready !== 1'b1) $display("FAIL stream_hold_ready: got %b want 1", bus.key_ready); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int n, bi, bl, bs, sp, e;
    load_key(K1, 1'b0);
    collect(50, n, bi, bl, bs, sp);
    e = model_errs();
    chk_cnt++; if (n != 72) $display("FAIL bp_beats: got %0d want 72", n); else pass_cnt++;
    chk_cnt++; if (bi != 0) $display("FAIL bp_idx_order: got %0d bad want 0", bi); else pass_cnt++;
    chk_cnt++; if (bs != 0) $display("FAIL bp_stable: got %0d unstable want 0", bs); else pass_cnt++;
    chk_cnt++; if (e != 0) $display("FAIL bp_model: got %0d wrong keys want 0", e); else pass_cnt++;
  endtask

  task automatic test_replay();
    int n, bi, bl, bs, sp, e;
    for (int i = 0; i < 72; i++) got[i] = '0;
    pulse_replay();
    collect(100, n, bi, bl, bs, sp);
    e = model_errs();
    chk_cnt++; if (n != 72) $display("FAIL replay_beats: got %0d want 72", n); else pass_cnt++;
    chk_cnt++; if (sp != 72) $display("FAIL replay_span: got %0d want 72", sp); else pass_cnt++;
    chk_cnt++; if (e != 0) $display("FAIL replay_model: got %0d wrong keys want 0", e); else pass_cnt++;
  endtask

  task automatic test_ignore_in_stream();
    int n = 0, cyc = 0, bad_ready = 0, e;
    pulse_replay();
    bus.key_data  = K2;
    bus.key_valid = 1'b1;
    bus.rk_ready  = 1'b1;
    while (n < 72 && cyc < 500) begin
      if (bus.key_ready !== 1'b0) bad_ready++;
      bus.replay = (bus.rk_valid === 1'b1) && (bus.rk_idx === 7'd10);
      if (bus.rk_valid === 1'b1) begin
        got[n] = bus.rk_data;
        n++;
      end
      cyc++;
      @(negedge clk);
    end
    bus.key_valid = 1'b0;
    bus.replay    = 1'b0;
    bus.rk_ready  = 1'b0;
    e = model_errs();
    chk_cnt++; if (n != 72) $display("FAIL ignore_beats: got %0d want 72", n); else pass_cnt++;
    chk_cnt++; if (bad_ready != 0) $display("FAIL ignore_key_ready: got %0d cycles high want 0", bad_ready); else pass_cnt++;
    chk_cnt++; if (e != 0) $display("FAIL ignore_model: got %0d wrong keys want 0", e); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (bus.rk_valid !== 1'b0) $display("FAIL ignore_no_restart: got %b want 0", bus.rk_valid); else pass_cnt++;
  endtask

  task automatic test_new_key_wins();
    int n, bi, bl, bs, sp, e;
    set_model(K2);
    load_key(K2, 1'b1);
    chk_cnt++; if (bus.rk_valid !== 1'b1) $display("FAIL newkey_valid: got %b want 1", bus.rk_valid); else pass_cnt++;
    chk_cnt++; if (bus.rk_idx !== 7'd0) $display("FAIL newkey_idx: got %0d want 0", bus.rk_idx); else pass_cnt++;
    chk_cnt++; if (bus.rk_data !== 64'h1122334455667788) $display("FAIL newkey_rk0: got %h want 1122334455667788", bus.rk_data); else pass_cnt++;
    collect(100, n, bi, bl, bs, sp);
    e = model_errs();
    chk_cnt++; if (n != 72) $display("FAIL newkey_beats: got %0d want 72", n); else pass_cnt++;
    chk_cnt++; if (e != 0) $display("FAIL newkey_model: got %0d wrong keys want 0", e); else pass_cnt++;
  endtask

  task automatic test_reset_mid_stream();
    int cyc = 0;
    pulse_replay();
    bus.rk_ready = 1'b1;
    while (!(bus.rk_valid === 1'b1 && bus.rk_idx === 7'd30) && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    chk_cnt++; if (bus.rk_idx !== 7'd30) $display("FAIL rstmid_reach_idx30: got %0d want 30", bus.rk_idx); else pass_cnt++;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.rk_ready = 1'b0;
    @(negedge clk);
    chk_cnt++; if (bus.rk_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", bus.rk_valid); else pass_cnt++;
    chk_cnt++; if (bus.key_loaded !== 1'b0) $display("FAIL rstmid_key_loaded: got %b want 0", bus.key_loaded); else pass_cnt++;
    chk_cnt++; if (bus.key_ready !== 1'b1) $display("FAIL rstmid_key_ready: got %b want 1", bus.key_ready); else pass_cnt++;
    chk_cnt++; if (bus.rk_idx !== 7'd0) $display("FAIL rstmid_idx: got %0d want 0", bus.rk_idx); else pass_cnt++;
    pulse_replay();
    repeat (3) @(negedge clk);
    chk_cnt++; if (bus.rk_valid !== 1'b0) $display("FAIL rstmid_replay_ignored: got %b want 0", bus.rk_valid); else pass_cnt++;
    chk_cnt++; if (bus.key_loaded !== 1'b0) $display("FAIL rstmid_still_unloaded: got %b want 0", bus.key_loaded); else pass_cnt++;
  endtask

  initial begin
    bus.key_data  = '0;
    bus.key_valid = 1'b0;
    bus.replay    = 1'b0;
    bus.rk_ready  = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_replay();
    test_ignore_in_stream();
    test_new_key_wins();
    test_reset_mid_stream();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
